// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding, read map and status layout for the pipeline performance monitor
package perf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} perf_state_e;
  localparam logic [2:0] ADDR_CYCLE    = 3'd0;
  localparam logic [2:0] ADDR_INSTRET  = 3'd1;
  localparam logic [2:0] ADDR_BUBBLE   = 3'd2;
  localparam logic [2:0] ADDR_RESULT   = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_START_PC = 3'd5;
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_W   = 2;
  localparam int STATUS_DONE_BIT  = 2;
endpackage

// File: rtl/pipeline_perf_monitor_if.sv
// pipeline_perf_monitor_if: core retire/debug taps, clear, read port and status of the monitor
interface pipeline_perf_monitor_if;
  logic [31:0] i_pc;
  logic        i_insn_vld;
  logic [31:0] i_ledr;
  logic        i_clr;
  logic        i_rd_en;
  logic [2:0]  i_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_vld;
  logic [1:0]  o_state;
  logic        o_done;
  modport master (output i_pc, i_insn_vld, i_ledr, i_clr, i_rd_en, i_rd_addr, input o_rd_data, o_rd_vld, o_state, o_done);
  modport slave (input i_pc, i_insn_vld, i_ledr, i_clr, i_rd_en, i_rd_addr, output o_rd_data, o_rd_vld, o_state, o_done);
endinterface

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: event counter with clear, load-to-one and increment that sticks at all-ones
module perf_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load1) cnt <= CNT_W'(1);
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: measures cycles/retired/bubbles from first nonzero pc until ledr changes, with a registered read port
module pipeline_perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  pipeline_perf_monitor_if.slave bus
);
  perf_state_e state;
  logic done, rd_vld, start, count;
  logic [31:0] ledr_base, result, start_pc, rd_data, rd_mux, status;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt, bubble_cnt;
  always_comb begin
    start = !bus.i_clr && state == IDLE && bus.i_pc != '0;
    count = !bus.i_clr && state == RUN && bus.i_ledr == ledr_base;
    status = '0;
    status[STATUS_STATE_LSB +: STATUS_STATE_W] = state;
    status[STATUS_DONE_BIT] = done;
    rd_mux = bus.i_rd_addr == ADDR_CYCLE    ? 32'(cycle_cnt)   :
             bus.i_rd_addr == ADDR_INSTRET  ? 32'(instret_cnt) :
             bus.i_rd_addr == ADDR_BUBBLE   ? 32'(bubble_cnt)  :
             bus.i_rd_addr == ADDR_RESULT   ? result           :
             bus.i_rd_addr == ADDR_STATUS   ? status           :
             bus.i_rd_addr == ADDR_START_PC ? start_pc         : '0;
  end
  perf_sat_counter #(.CNT_W(CNT_W)) u_cycle (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clr(bus.i_clr),
    .load1(start), .inc(count), .cnt(cycle_cnt));
  perf_sat_counter #(.CNT_W(CNT_W)) u_instret (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clr(bus.i_clr),
    .load1(start && bus.i_insn_vld), .inc(count && bus.i_insn_vld), .cnt(instret_cnt));
  perf_sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clr(bus.i_clr),
    .load1(start && !bus.i_insn_vld), .inc(count && !bus.i_insn_vld), .cnt(bubble_cnt));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      ledr_base <= '0;
      result <= '0;
      start_pc <= '0;
      rd_data <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= bus.i_rd_en;
      if (bus.i_rd_en) rd_data <= rd_mux;
      if (bus.i_clr) begin
        state <= IDLE;
        done <= 1'b0;
        ledr_base <= '0;
        result <= '0;
        start_pc <= '0;
      end else
        case (state)
          IDLE:
            if (bus.i_pc != '0) begin
              state <= RUN;
              ledr_base <= bus.i_ledr;
              start_pc <= bus.i_pc;
            end
          RUN:
            if (bus.i_ledr != ledr_base) begin
              state <= DONE;
              done <= 1'b1;
              result <= bus.i_ledr;
            end
          DONE: ;
          default: begin
            state <= IDLE;
            done <= 1'b0;
          end
        endcase
    end
  assign bus.o_rd_data = rd_data;
  assign bus.o_rd_vld = rd_vld;
  assign bus.o_state = state;
  assign bus.o_done = done;
endmodule

// File: doc/pipeline_perf_monitor.md
# pipeline_perf_monitor

Non-intrusive performance monitor attached to the pipeline's retire/debug outputs. It measures one program run on the core. The run starts when the debug PC first leaves zero and ends when the LEDR output register first changes. Over that window it counts total cycles, retired instructions and bubble cycles, captures the LEDR result, and exposes everything through a small registered read port, so cycle, instruction and IPC figures are available in hardware and on the FPGA as well as in simulation.

## Interface
- CNT_W, 32, width of each event counter (4..32); values zero-extended to 32 bits on read
- i_clk  in  1  clock
- i_rst_n  in  1  reset: asynchronous, active-low
- i_pc  in  32  pipeline debug PC (o_pc_debug of the core)
- i_insn_vld  in  1  instruction retired this cycle (o_insn_vld of the core)
- i_ledr  in  32  core LEDR output register (o_io_ledr)
- i_clr  in  1  synchronous clear; returns the monitor to IDLE
- i_rd_en  in  1  read request
- i_rd_addr  in  3  read word select
- o_rd_data  out  32  read data, registered
- o_rd_vld  out  1  read data valid, one-cycle pulse
- o_state  out  2  FSM state: IDLE=0, RUN=1, DONE=2
- o_done  out  1  high while in DONE

## Operation
- FSM states: IDLE, RUN, DONE. Encoding 3 is unused and recovers to IDLE.
- IDLE: counters hold 0. At an edge where i_pc != 0, the FSM moves to RUN and at the same edge:
  - cycle_cnt <= 1
  - instret_cnt <= i_insn_vld
  - bubble_cnt <= !i_insn_vld
  - ledr_base <= i_ledr
  - start_pc <= i_pc
- RUN, at each edge:
  - If i_ledr != ledr_base: go to DONE and set result <= i_ledr. Counters are NOT incremented on this edge.
  - Otherwise: cycle_cnt += 1, and exactly one of instret_cnt or bubble_cnt += 1 per i_insn_vld.
- Invariant in RUN and DONE: cycle_cnt == instret_cnt + bubble_cnt, unless a counter has saturated.
- Counters saturate at 2^CNT_W-1 and never wrap. Each counter saturates independently.
- i_pc returning to 0 during RUN has no effect on the FSM; those cycles are counted normally.
- DONE: all counters, result and start_pc are frozen. Only i_clr or reset leaves DONE.
- i_clr: from any state, at the next edge go to IDLE and zero all counters, ledr_base, result and start_pc. i_clr has priority over start detection and end detection on the same edge.
- Read map (i_rd_addr):
  - 0: cycle_cnt
  - 1: instret_cnt
  - 2: bubble_cnt
  - 3: result
  - 4: status {29'b0, o_done, o_state}
  - 5: start_pc
  - 6, 7: return 0
- Reads are legal in any state and have no side effects.

## Timing
- Reset (async): FSM to IDLE; all counters, result, ledr_base, start_pc, o_rd_data, o_rd_vld, o_state and o_done go to 0.
- Read latency is 1 cycle. When i_rd_en is sampled high at edge N:
  - o_rd_data is valid after edge N.
  - o_rd_vld is high for exactly the cycle after edge N.
  - Back-to-back reads are allowed, one per cycle.
- A read and an update on the same edge return the pre-update value. This includes a read that coincides with i_clr, which returns the pre-clear value.
- o_state and o_done are registered and reflect the FSM state after each edge.
- Start and end detection both use values sampled at the edge, with no synchronizers; all inputs are synchronous to i_clk.
- If ledr changes at the same edge the FSM enters RUN: the new value becomes ledr_base, and that change is not treated as the end event.

## Structure
- Shared package perf_pkg:
  - state enum perf_state_e (IDLE/RUN/DONE)
  - read address localparams ADDR_CYCLE..ADDR_START_PC
  - STATUS field positions
- One sub-module, perf_sat_counter (parameter CNT_W; inputs clr, load1, inc; output cnt, saturating). It is instantiated three times, for cycle, instret and bubble.
- The top level holds the FSM, the ledr_base/result/start_pc registers and the read mux.

## Test plan
- Reset check: hold i_rst_n low with random inputs -> every read address returns 0 after release, o_state=0, o_rd_vld=0.
- Basic run: i_pc=0 for 5 cycles, then 0x4. Drive i_insn_vld pattern 1,1,0,1,1,0,1,1,0,1. Change i_ledr from 0 to 5050 on the 11th RUN edge -> cycle=10, instret=7, bubble=3, result=5050, start_pc=0x4, o_done=1. Counters then stay frozen for 20 more cycles.
- Read port: read addresses 0..7 back-to-back in DONE -> data appears one cycle after each request, o_rd_vld high for 8 consecutive cycles, addresses 6 and 7 return 0.
- Saturation: CNT_W=4, 20 RUN cycles with i_insn_vld=1 -> cycle=15, instret=15, bubble=0, with no wrap.
- Clear mid-run: i_clr pulsed during RUN with a simultaneous i_rd_en at addr 0 -> read returns the pre-clear count. Next state is IDLE with counters 0. A new pc!=0 restarts with cycle=1.
- Async reset mid-run: drop i_rst_n between edges during RUN -> o_state=0 and all outputs 0 immediately, without waiting for a clock edge.
